// File: rtl/bus_fill_monitor_if.sv
// Fill-bus monitor port bundle: sampled bus input, event stream and status outputs.
// The master side drives the bus and event-ready; the slave side is the monitor.
interface bus_fill_monitor_if #(
  parameter int WIDTH = 10,
  parameter int IDX_W = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] BUS_IN;
  logic             EVT_VALID;
  logic             EVT_READY;
  logic [IDX_W-1:0] EVT_IDX;
  logic [CNT_W-1:0] POP_CNT;
  logic             ALL_SET;
  logic             ORDER_ERR;

  modport master (
    output BUS_IN,
    output EVT_READY,
    input  EVT_VALID,
    input  EVT_IDX,
    input  POP_CNT,
    input  ALL_SET,
    input  ORDER_ERR
  );

  modport slave (
    input  BUS_IN,
    input  EVT_READY,
    output EVT_VALID,
    output EVT_IDX,
    output POP_CNT,
    output ALL_SET,
    output ORDER_ERR
  );
endinterface

// File: rtl/bus_fill_monitor.sv
// Fill-bus monitor: queues the index of every newly set bus bit on a FWFT valid/ready stream,
// reports live popcount and an all-set pulse. Optional order checker: BUS_FILL_ORDER_CHK_EN.
module bus_fill_monitor #(
  parameter int WIDTH      = 10,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  bus_fill_monitor_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] onehot);
    logic [IDX_W-1:0] e;
    e = '0;
    for (int i = 0; i < WIDTH; i++) if (onehot[i]) e = e | IDX_W'(i);
    return e;
  endfunction

  logic [WIDTH-1:0] bus_q_p0;
  logic [WIDTH-1:0] bus_p_p1;
  logic             primed_p0;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] sel;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic [CNT_W-1:0] pop_cnt_p1;
  logic             all_set_p1;

  // ---- stage p0/p1: bus sampling ----
  // On the first edge the previous sample is seeded with the same value, so
  // bits already high when the bus is first seen never count as rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus_q_p0  <= '0;
      bus_p_p1  <= '0;
      primed_p0 <= 1'b0;
    end else begin
      bus_q_p0  <= bus.BUS_IN;
      bus_p_p1  <= primed_p0 ? bus_q_p0 : bus.BUS_IN;
      primed_p0 <= 1'b1;
    end
  end

  always_comb begin
    rise = '0;
    if (primed_p0) rise = bus_q_p0 & ~bus_p_p1;
  end

  // ---- stage p1: pending mask and lowest-first selection ----
  assign lowest    = pend & (~pend + WIDTH'(1));
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign evt_valid = (wr_ptr != rd_ptr);
  assign pop       = evt_valid && bus.EVT_READY;
  assign push      = (|pend) && (!full || pop);
  assign sel       = push ? lowest : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pend <= '0;
    else        pend <= (pend & ~sel) | rise;
  end

  // ---- stage p2: event FIFO (first-word-fall-through) ----
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= encode(sel);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset, so the head index is forced to zero while empty.
  assign evt_idx = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // ---- stage p1: popcount and all-set edge ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pop_cnt_p1 <= '0;
      all_set_p1 <= 1'b0;
    end else begin
      pop_cnt_p1 <= popcount(bus_q_p0);
      all_set_p1 <= (popcount(bus_q_p0) == CNT_W'(WIDTH)) && (pop_cnt_p1 != CNT_W'(WIDTH));
    end
  end

`ifdef BUS_FILL_ORDER_CHK_EN
  logic [IDX_W-1:0] exp_idx;
  logic             order_err;

  // ---- order checker: each popped index must follow the previous one ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_idx   <= '0;
      order_err <= 1'b0;
    end else if (pop) begin
      if (evt_idx != exp_idx) order_err <= 1'b1;
      exp_idx <= (evt_idx == IDX_W'(WIDTH - 1)) ? '0 : evt_idx + IDX_W'(1);
    end
  end

  assign bus.ORDER_ERR = order_err;
`else
  assign bus.ORDER_ERR = 1'b0;
`endif

  assign bus.EVT_VALID = evt_valid;
  assign bus.EVT_IDX   = evt_idx;
  assign bus.POP_CNT   = pop_cnt_p1;
  assign bus.ALL_SET   = all_set_p1;
endmodule

// File: tb/tb_bus_fill_monitor.sv
// Randomised and directed bench for bus_fill_monitor against a queue-based reference model.
// Define BUS_FILL_ORDER_CHK_EN at compile time to exercise the order checker.
module tb_bus_fill_monitor;
  localparam int W  = 10;
  localparam int IW = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_fill_monitor_if #(.WIDTH(W), .IDX_W(IW)) bif ();

  bus_fill_monitor #(.WIDTH(W), .IDX_W(IW), .FIFO_DEPTH(D)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bif.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: sample history, set of waiting indices, event queue.
  int           n_smp;
  logic [W-1:0] m_cur, m_prev;
  bit           m_pend [W];
  int           m_fifo [$];
  int           m_cnt;
  bit           m_all;
  int           m_exp;
  bit           m_err;

  int pop_idx [$];
  int pop_step [$];
  int step_no = 0;
  int all_cnt = 0;

  task automatic model_reset();
    n_smp = 0; m_cur = '0; m_prev = '0; m_cnt = 0; m_all = 0; m_exp = 0; m_err = 0;
    for (int i = 0; i < W; i++) m_pend[i] = 0;
    m_fifo.delete();
  endtask

  task automatic model_edge(input logic [W-1:0] b, input logic r);
    bit popped;
    int low;
    int newcnt;
    popped = (m_fifo.size() > 0) && r;
    low = -1;
    for (int i = W - 1; i >= 0; i--) if (m_pend[i]) low = i;
    newcnt = $countones(m_cur);
    m_all = (newcnt == W) && (m_cnt != W);
    m_cnt = newcnt;
    if (popped) begin
      if (m_fifo[0] != m_exp) m_err = 1;
      m_exp = (m_fifo[0] + 1) % W;
      void'(m_fifo.pop_front());
    end
    if (low >= 0 && m_fifo.size() < D) begin
      m_fifo.push_back(low);
      m_pend[low] = 0;
    end
    if (n_smp >= 2)
      for (int i = 0; i < W; i++) if (m_cur[i] && !m_prev[i]) m_pend[i] = 1;
    m_prev = m_cur;
    m_cur  = b;
    n_smp++;
  endtask

  function automatic bit exp_oe();
`ifdef BUS_FILL_ORDER_CHK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  // Called just after an active edge: drive inputs, log a pending pop, advance one clock.
  task automatic step(input logic [W-1:0] b, input logic r);
    bif.BUS_IN    = b;
    bif.EVT_READY = r;
    if (rst_n && bif.EVT_VALID && r) begin
      pop_idx.push_back(int'(bif.EVT_IDX));
      pop_step.push_back(step_no);
    end
    @(posedge clk);
    if (rst_n) model_edge(b, r);
    else       model_reset();
    #1;
    if (bif.ALL_SET) all_cnt++;
    step_no++;
  endtask

  task automatic apply_reset(input logic [W-1:0] b);
    rst_n = 1'b0;
    model_reset();
    step(b, 1'b1);
    rst_n = 1'b1;
    step(b, 1'b1);
    step(b, 1'b1);
    pop_idx.delete();
    pop_step.delete();
    all_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.BUS_IN = '1;
    bif.EVT_READY = 1'b1;
    model_reset();
    #1;
    checks++; if (bif.EVT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", bif.EVT_VALID); end
    checks++; if (bif.EVT_IDX !== '0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", bif.EVT_IDX); end
    checks++; if (bif.POP_CNT !== '0) begin errors++; $display("FAIL rst_popcnt: got %0d expected 0", bif.POP_CNT); end
    checks++; if (bif.ALL_SET !== 1'b0) begin errors++; $display("FAIL rst_allset: got %0b expected 0", bif.ALL_SET); end
    checks++; if (bif.ORDER_ERR !== 1'b0) begin errors++; $display("FAIL rst_ordererr: got %0b expected 0", bif.ORDER_ERR); end
    step('1, 1'b1);
    step('1, 1'b1);
    rst_n = 1'b1;
    pop_idx.delete(); pop_step.delete(); all_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step('1, 1'b1);
      checks++; if (bif.EVT_VALID !== 1'b0) begin errors++; $display("FAIL high_no_evt: cycle %0d got %0b expected 0", i, bif.EVT_VALID); end
      checks++; if (bif.POP_CNT !== CW'(m_cnt)) begin errors++; $display("FAIL high_popcnt: cycle %0d got %0d expected %0d", i, bif.POP_CNT, m_cnt); end
      if (i == 1) begin
        checks++; if (bif.POP_CNT !== CW'(W)) begin errors++; $display("FAIL high_popcnt_full: got %0d expected %0d", bif.POP_CNT, W); end
        checks++; if (bif.ALL_SET !== 1'b1) begin errors++; $display("FAIL high_allset: got %0b expected 1", bif.ALL_SET); end
      end
    end
    checks++; if (all_cnt !== 1) begin errors++; $display("FAIL high_allset_count: got %0d expected 1", all_cnt); end
    checks++; if (pop_idx.size() !== 0) begin errors++; $display("FAIL high_events: got %0d expected 0", pop_idx.size()); end
  endtask

  task automatic test_walk();
    logic [W-1:0] b;
    int base;
    apply_reset('0);
    b = '0;
    base = step_no;
    for (int k = 0; k < W + 6; k++) begin
      if (k < W) b = b | W'(1 << k);
      step(b, 1'b1);
      checks++; if (bif.EVT_VALID !== (m_fifo.size() > 0)) begin errors++; $display("FAIL walk_valid: cycle %0d got %0b expected %0b", k, bif.EVT_VALID, m_fifo.size() > 0); end
    end
    checks++; if (pop_idx.size() !== W) begin errors++; $display("FAIL walk_count: got %0d expected %0d", pop_idx.size(), W); end
    for (int i = 0; i < pop_idx.size(); i++) begin
      checks++; if (pop_idx[i] !== i) begin errors++; $display("FAIL walk_idx: pos %0d got %0d expected %0d", i, pop_idx[i], i); end
      checks++; if (pop_step[i] - base !== i + 3) begin errors++; $display("FAIL walk_latency: idx %0d got %0d expected %0d", i, pop_step[i] - base, i + 3); end
    end
    checks++; if (all_cnt !== 1) begin errors++; $display("FAIL walk_allset_count: got %0d expected 1", all_cnt); end
    checks++; if (bif.ORDER_ERR !== 1'b0) begin errors++; $display("FAIL walk_ordererr: got %0b expected 0", bif.ORDER_ERR); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] b;
    apply_reset('0);
    b = '0;
    for (int k = 0; k < 12; k++) begin
      if (k < W) b = b | W'(1 << k);
      step(b, 1'b0);
      if (k >= 2) begin
        checks++; if (bif.EVT_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid_held: cycle %0d got %0b expected 1", k, bif.EVT_VALID); end
        checks++; if (bif.EVT_IDX !== IW'(0)) begin errors++; $display("FAIL bp_idx_held: cycle %0d got %0d expected 0", k, bif.EVT_IDX); end
      end
    end
    for (int k = 0; k < 16; k++) begin
      step(b, 1'b1);
      checks++; if (bif.EVT_VALID !== (m_fifo.size() > 0)) begin errors++; $display("FAIL bp_drain_valid: cycle %0d got %0b expected %0b", k, bif.EVT_VALID, m_fifo.size() > 0); end
    end
    checks++; if (pop_idx.size() !== W) begin errors++; $display("FAIL bp_count: got %0d expected %0d", pop_idx.size(), W); end
    for (int i = 0; i < pop_idx.size(); i++) begin
      checks++; if (pop_idx[i] !== i) begin errors++; $display("FAIL bp_order: pos %0d got %0d expected %0d", i, pop_idx[i], i); end
    end
    // The first four events were queued during backpressure and drain back to back.
    if (pop_step.size() >= 4) begin
      checks++; if (pop_step[3] - pop_step[0] !== 3) begin errors++; $display("FAIL bp_drain_rate: got %0d expected 3", pop_step[3] - pop_step[0]); end
    end
  endtask

  task automatic test_simultaneous();
    int exp_seq [4];
    exp_seq = '{0, 2, 5, 7};
    apply_reset('0);
    for (int k = 0; k < 10; k++) step(W'(10'h0A5), 1'b1);
    checks++; if (pop_idx.size() !== 4) begin errors++; $display("FAIL simul_count: got %0d expected 4", pop_idx.size()); end
    for (int i = 0; i < 4 && i < pop_idx.size(); i++) begin
      checks++; if (pop_idx[i] !== exp_seq[i]) begin errors++; $display("FAIL simul_idx: pos %0d got %0d expected %0d", i, pop_idx[i], exp_seq[i]); end
      checks++; if (pop_step[i] - pop_step[0] !== i) begin errors++; $display("FAIL simul_consecutive: pos %0d got %0d expected %0d", i, pop_step[i] - pop_step[0], i); end
    end
  endtask

  task automatic test_order_checker();
    bit fin;
    apply_reset('0);
    step(W'(1 << 3), 1'b1);
    step(W'((1 << 3) | (1 << 1)), 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(W'((1 << 3) | (1 << 1)), 1'b1);
      checks++; if (bif.ORDER_ERR !== exp_oe()) begin errors++; $display("FAIL order_err_track: cycle %0d got %0b expected %0b", k, bif.ORDER_ERR, exp_oe()); end
    end
    checks++; if (pop_idx.size() !== 2) begin errors++; $display("FAIL order_count: got %0d expected 2", pop_idx.size()); end
    if (pop_idx.size() == 2) begin
      checks++; if (pop_idx[0] !== 3 || pop_idx[1] !== 1) begin errors++; $display("FAIL order_seq: got %0d,%0d expected 3,1", pop_idx[0], pop_idx[1]); end
    end
`ifdef BUS_FILL_ORDER_CHK_EN
    fin = 1'b1;
`else
    fin = 1'b0;
`endif
    checks++; if (bif.ORDER_ERR !== fin) begin errors++; $display("FAIL order_err_final: got %0b expected %0b", bif.ORDER_ERR, fin); end
  endtask

  task automatic test_random();
    logic [W-1:0] b;
    logic r;
    apply_reset(W'($urandom));
    b = bif.BUS_IN;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 4))
        0, 1: b = b | W'(1 << $urandom_range(0, W - 1));
        2:    b = b & ~W'(1 << $urandom_range(0, W - 1));
        3:    b = W'($urandom);
        default: ;
      endcase
      r = ($urandom_range(0, 3) != 0);
      step(b, r);
      checks++; if (bif.EVT_VALID !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_valid: cycle %0d got %0b expected %0b", k, bif.EVT_VALID, m_fifo.size() > 0); end
      if (m_fifo.size() > 0) begin
        checks++; if (bif.EVT_IDX !== IW'(m_fifo[0])) begin errors++; $display("FAIL rnd_idx: cycle %0d got %0d expected %0d", k, bif.EVT_IDX, m_fifo[0]); end
      end
      checks++; if (bif.POP_CNT !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_popcnt: cycle %0d got %0d expected %0d", k, bif.POP_CNT, m_cnt); end
      checks++; if (bif.ALL_SET !== m_all) begin errors++; $display("FAIL rnd_allset: cycle %0d got %0b expected %0b", k, bif.ALL_SET, m_all); end
      checks++; if (bif.ORDER_ERR !== exp_oe()) begin errors++; $display("FAIL rnd_ordererr: cycle %0d got %0b expected %0b", k, bif.ORDER_ERR, exp_oe()); end
    end
  endtask

  task automatic test_midrun_reset();
    logic [W-1:0] b;
    int guard;
    apply_reset('0);
    b = '0;
    guard = 0;
    while (m_fifo.size() < 3 && guard < 20) begin
      if (guard < W) b = b | W'(1 << guard);
      step(b, 1'b0);
      guard++;
    end
    checks++; if (bif.EVT_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b expected 1 after %0d cycles", bif.EVT_VALID, guard); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bif.EVT_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", bif.EVT_VALID); end
    checks++; if (bif.POP_CNT !== '0) begin errors++; $display("FAIL mid_popcnt: got %0d expected 0", bif.POP_CNT); end
    step(b, 1'b1);
    rst_n = 1'b1;
    pop_idx.delete(); pop_step.delete();
    for (int k = 0; k < 8; k++) begin
      step(b, 1'b1);
      checks++; if (bif.EVT_VALID !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d got %0b expected 0", k, bif.EVT_VALID); end
    end
    checks++; if (pop_idx.size() !== 0) begin errors++; $display("FAIL mid_stale_count: got %0d expected 0", pop_idx.size()); end
  endtask

  initial begin
    bif.BUS_IN = '0;
    bif.EVT_READY = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_walk();
    test_backpressure();
    test_simultaneous();
    test_order_checker();
    test_random();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/bus_fill_monitor.md
# bus_fill_monitor

Downstream consumer of the 10-bit fill bus produced by the bus test generator, which sets one bus bit per clock. Samples the bus, detects each newly set bit, and queues its bit index as an event on a valid/ready stream. Also reports the live count of set bits and a one-cycle pulse when the bus becomes fully set. Sits between the fill-bus generator and any logging or checking stage.

## Interface
- `WIDTH`, 10: bus width; legal range 2..16.
- `IDX_W`, 4: event index width; must satisfy 2^IDX_W ≥ WIDTH.
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥ 2.

- `CLK`, in, 1: sole clock, rising edge.
- `RST_N`, in, 1: asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- `BUS_IN`, in, WIDTH: fill bus from the upstream generator.
- `EVT_VALID`, out, 1: event queue non-empty.
- `EVT_READY`, in, 1: consumer accepts the head event.
- `EVT_IDX`, out, IDX_W: bit index of the head event.
- `POP_CNT`, out, $clog2(WIDTH+1): number of set bits in the sampled bus.
- `ALL_SET`, out, 1: one-cycle pulse when `POP_CNT` reaches WIDTH.
- `ORDER_ERR`, out, 1: sticky order-violation flag (see Configuration).

## Operation
- **Sampling:** `BUS_Q` ← `BUS_IN` every edge. `BUS_P` ← `BUS_Q`. A `PRIMED` flag is set on the first edge after reset.
- **Rise vector:** `rise = BUS_Q & ~BUS_P`, gated to zero while `PRIMED` = 0. Bits already high on the first sample never produce events.
- **Pending mask:** `PEND` ← `(PEND & ~sel) | rise`. `sel` is a one-hot mask of the lowest-index set bit of `PEND`. It is nonzero only when a push occurs.
- **Push:** happens when `PEND` ≠ 0 and (queue not full, or a pop occurs in the same cycle). On a push, the encoded index of `sel` is written to the FIFO.
- **Event ordering:** at most one event is queued per cycle. Simultaneous rises are queued lowest index first, on successive cycles. Pending bits never get lost; they wait in `PEND` while the queue is full.
- **Falling bits:** ignored for events. They are reflected only in `POP_CNT`.
- **Pop:** happens when `EVT_VALID` && `EVT_READY`. The FIFO is first-word-fall-through: `EVT_IDX` is valid whenever `EVT_VALID` = 1.
- **Handshake hold rule:** `EVT_IDX` is stable while `EVT_VALID` is high and `EVT_READY` is low.
- **`POP_CNT`:** registered popcount of `BUS_Q`. Width arithmetic is unsigned with no overflow, since the maximum is WIDTH.
- **`ALL_SET`:** high for one cycle when `POP_CNT` becomes WIDTH from a smaller value. It does not re-fire until `POP_CNT` drops below WIDTH and returns.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`, with an extra bit for full/empty.

## Timing
- **Reset values:** `EVT_VALID`=0, `EVT_IDX`=0, `POP_CNT`=0, `ALL_SET`=0, `ORDER_ERR`=0. Internal `BUS_Q`, `BUS_P`, `PEND`, `PRIMED` and the FIFO pointers are all 0.
- **Reset mid-operation:** clears everything immediately. Queued and pending events are discarded.
- **Event latency:** a bit first sampled high in `BUS_Q` at edge N appears in `PEND` at edge N+1 and is written to the FIFO at edge N+2. `EVT_VALID` is high after edge N+2 if the queue was empty and no lower pending bit exists.
- **`POP_CNT` latency:** reflects `BUS_Q` with a 1-cycle latency. `ALL_SET` is asserted in the same cycle `POP_CNT` first equals WIDTH.
- **Full queue with pop and push in the same cycle:** both occur; occupancy is unchanged.
- **Empty queue with push:** no same-cycle bypass; `EVT_VALID` rises the cycle after the push.
- **Throughput:** sustained 1 event/cycle with `EVT_READY` held high.

## Configuration
- **`BUS_FILL_ORDER_CHK_EN` defined:**
  - An expected-index register (reset 0) is compared with `EVT_IDX` on each pop.
  - A mismatch sets `ORDER_ERR` on the next edge; it stays set until reset.
  - After each pop, expected ← `(EVT_IDX + 1) % WIDTH`.
- **`BUS_FILL_ORDER_CHK_EN` undefined:** `ORDER_ERR` is tied to 0 and no checker logic is present.

## Test plan
- **Reset with bus high:** `BUS_IN`=10'h3FF through reset release. Required: no events, `POP_CNT`=10 after 1 cycle, `ALL_SET` pulses once.
- **Upstream walk, ready high:**
  - Stimulus: bits set 0..9 one per cycle from 0, `EVT_READY`=1.
  - Required: `EVT_IDX` sequence 0..9, each 3 cycles after its bit is set.
  - Required: `ALL_SET` pulses exactly once, `ORDER_ERR`=0.
- **Backpressure:** same walk with `EVT_READY`=0 for 12 cycles, then 1. Required: `EVT_VALID` held, 4 entries queued, remaining indices drained afterward in order 0..9 with none lost.
- **Simultaneous rises:** `BUS_IN` 0 → 10'h0A5 in one cycle. Required: events 0, 2, 5, 7 on consecutive cycles.
- **Order checker (macro defined):** rises on bit 3 then bit 1. Required: `ORDER_ERR`=1 after the first pop (idx 3 ≠ 0) and remains set.
- **Mid-run reset:** assert `RST_N` with 3 events queued. Required: `EVT_VALID`=0 immediately, `POP_CNT`=0, no stale events after release.
